// File: rtl/uvmt_st_pkg.sv
// Shared types and constants for the uvmt_st stream generator slice:
// FSM state encoding, LFSR tap constant and default parameter values.
package uvmt_st_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_LEN_W  = 8;
    localparam int unsigned DEF_GAP_W  = 4;

    // Galois LFSR feedback taps for an 8-bit register
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/uvmt_st_lfsr.sv
// Galois LFSR next-value function (right-shifting, taps XORed in when the
// bit shifted out is 1). Only instantiated when UVMT_ST_TX_GEN_LFSR_EN is set.
module uvmt_st_lfsr
    import uvmt_st_pkg::*;
#(
    parameter int unsigned       DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] TAPS   = DATA_W'(LFSR_TAPS)
) (
    input  logic [DATA_W-1:0] cur,
    output logic [DATA_W-1:0] nxt
);

    // One LFSR step
    always_comb begin
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ TAPS;
        end
    end

endmodule

// File: rtl/uvmt_st_tx_gen.sv
// Stream burst generator: accepts a command (length, start value, inter-beat
// gap, mode) and emits cmd_len+1 beats, optionally separated by idle cycles.
// Build option: define UVMT_ST_TX_GEN_LFSR_EN to compile in the LFSR data
// mode; otherwise cmd_mode is ignored and every burst is incrementing.
module uvmt_st_tx_gen
    import uvmt_st_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned GAP_W  = DEF_GAP_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_start,
    input  logic [GAP_W-1:0]  cmd_gap,
    input  logic              cmd_mode,
    input  logic              abort,
    output logic              enable,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done
);

    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);
    localparam logic [LEN_W:0]    BEAT_ONE = (LEN_W+1)'(1);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

    tx_state_e         state;
    tx_state_e         state_nxt;

    // Extra bit so a 256-beat burst (cmd_len = all ones) fits without wrap
    logic [LEN_W:0]    beats_left;
    logic [GAP_W-1:0]  gap_lat;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] cur_data;
    logic [DATA_W-1:0] nxt_data;
    logic [DATA_W-1:0] seed;
    logic              done_q;

`ifdef UVMT_ST_TX_GEN_LFSR_EN
    logic              mode_q;
    logic [DATA_W-1:0] lfsr_next;

    uvmt_st_lfsr #(
        .DATA_W (DATA_W),
        .TAPS   (DATA_W'(LFSR_TAPS))
    ) u_lfsr (
        .cur (cur_data),
        .nxt (lfsr_next)
    );

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    assign seed     = (cmd_mode && (cmd_start == '0)) ? DATA_ONE : cmd_start;
    assign nxt_data = mode_q ? lfsr_next : (cur_data + DATA_ONE);

    // Burst mode latched with the command
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= 1'b0;
        end else if (state == ST_IDLE && cmd_valid) begin
            mode_q <= cmd_mode;
        end
    end
`else
    logic unused_cmd_mode;

    assign unused_cmd_mode = cmd_mode;
    assign seed            = cmd_start;
    assign nxt_data        = cur_data + DATA_ONE;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and stream outputs; ready is also held low during reset
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        enable    = 1'b0;
        data      = '0;
        case (state)
            ST_IDLE: begin
                cmd_ready = reset_n;
                if (cmd_valid) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                enable = 1'b1;
                data   = cur_data;
                if (abort || beats_left == BEAT_ONE) begin
                    state_nxt = ST_IDLE;
                end else if (gap_lat != '0) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (gap_cnt == GAP_ONE) begin
                    state_nxt = ST_SEND;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Burst datapath: command latch, beat/gap counters, data sequence, done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beats_left <= '0;
            gap_lat    <= '0;
            gap_cnt    <= '0;
            cur_data   <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cur_data   <= seed;
                        beats_left <= {1'b0, cmd_len} + BEAT_ONE;
                        gap_lat    <= cmd_gap;
                    end
                end
                ST_SEND: begin
                    if (!abort) begin
                        if (beats_left == BEAT_ONE) begin
                            done_q <= 1'b1;
                        end else begin
                            beats_left <= beats_left - BEAT_ONE;
                            cur_data   <= nxt_data;
                            gap_cnt    <= gap_lat;
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - GAP_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_uvmt_st_tx_gen.sv
// Self-checking bench for uvmt_st_tx_gen: directed scenarios plus random
// bursts, each compared cycle by cycle against a per-burst expected schedule.
module tb_uvmt_st_tx_gen;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_len;
    logic [7:0] cmd_start;
    logic [3:0] cmd_gap;
    logic       cmd_mode;
    logic       abort;
    logic       enable;
    logic [7:0] data;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    uvmt_st_tx_gen #(
        .DATA_W (8),
        .LEN_W  (8),
        .GAP_W  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_start (cmd_start),
        .cmd_gap   (cmd_gap),
        .cmd_mode  (cmd_mode),
        .abort     (abort),
        .enable    (enable),
        .data      (data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value of the beat following v, from the data-sequence rules
    function automatic logic [7:0] step(input logic [7:0] v, input logic lfsr_mode);
`ifdef UVMT_ST_TX_GEN_LFSR_EN
        if (lfsr_mode) return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
`endif
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] first_value(input logic [7:0] s, input logic lfsr_mode);
`ifdef UVMT_ST_TX_GEN_LFSR_EN
        if (lfsr_mode && s == 8'd0) return 8'd1;
`endif
        return s;
    endfunction

    // abort_beat: 1-based beat during which abort is raised (0 = none)
    task automatic run_burst(input int len, input logic [7:0] start, input int gap,
                             input logic mode, input int abort_beat, input logic abort_at_accept);
        logic       exp_en[$];
        logic [7:0] exp_dat[$];
        logic [7:0] v;
        bit         aborted;
        aborted = 1'b0;
        v = first_value(start, mode);
        for (int i = 0; i <= len; i++) begin
            exp_en.push_back(1'b1);
            exp_dat.push_back(v);
            v = step(v, mode);
            if (abort_beat == i + 1) begin
                aborted = 1'b1;
                break;
            end
            if (i < len) begin
                for (int g = 0; g < gap; g++) begin
                    exp_en.push_back(1'b0);
                    exp_dat.push_back(8'd0);
                end
            end
        end

        @(negedge clk);
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_len   = 8'(len);
        cmd_start = start;
        cmd_gap   = 4'(gap);
        cmd_mode  = mode;
        abort     = abort_at_accept;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        for (int s = 0; s < exp_en.size(); s++) begin
            abort = (aborted && s == exp_en.size() - 1);
            @(negedge clk);
            chk("beat_enable", 32'(enable), 32'(exp_en[s]));
            chk("beat_data", 32'(data), 32'(exp_dat[s]));
            chk("beat_busy", 32'(busy), 32'd1);
            chk("beat_done", 32'(done), 32'd0);
            chk("beat_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
        @(negedge clk);
        chk("end_enable", 32'(enable), 32'd0);
        chk("end_data", 32'(data), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ready", 32'(cmd_ready), 32'd1);
        chk("end_done", 32'(done), aborted ? 32'd0 : 32'd1);
        if (!aborted) begin
            @(negedge clk);
            chk("done_single_pulse", 32'(done), 32'd0);
        end
    endtask

    // Start a burst, pull reset low partway through slot 'slot', then release
    task automatic reset_mid_burst(input int slot);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = 8'd7;
        cmd_start = 8'h40;
        cmd_gap   = 4'd3;
        cmd_mode  = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (slot) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 32'(cmd_ready), 32'd1);
        chk("rst_release_done", 32'(done), 32'd0);
        chk("rst_release_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rst_release_done2", 32'(done), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_start = '0;
        cmd_gap   = '0;
        cmd_mode  = 1'b0;
        abort     = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_enable", 32'(enable), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Back-to-back with wrap: FE FF 00 01
        run_burst(3, 8'hFE, 0, 1'b0, 0, 1'b0);
        // Gapped: 10, idle, idle, 11
        run_burst(1, 8'h10, 2, 1'b0, 0, 1'b0);
        // Mode 1 with zero start: 01 B8 5C with LFSR built in, else 00 01 02
        run_burst(2, 8'h00, 0, 1'b1, 0, 1'b0);
        // Abort on the 3rd beat of a 10-beat burst, then an immediate new command
        run_burst(9, 8'h33, 0, 1'b0, 3, 1'b0);
        run_burst(2, 8'h80, 1, 1'b0, 0, 1'b0);
        // Abort while idle is ignored and the command is still accepted
        run_burst(4, 8'h05, 1, 1'b0, 0, 1'b1);
        // Maximum length burst
        run_burst(255, 8'($urandom_range(0, 255)), 0, 1'b0, 0, 1'b0);

        // Random bursts, some aborted
        for (int n = 0; n < 12; n++) begin
            int l;
            int ab;
            l  = int'($urandom_range(0, 15));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, l + 1)) : 0;
            run_burst(l, 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), ab, 1'b0);
        end

        // Reset during SEND (first beat) and during GAP
        reset_mid_burst(0);
        reset_mid_burst(2);
        run_burst(2, 8'hA0, 0, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
